// File: rtl/fu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fu_wb_arbiter
//   Shares a single writeback bus between NUM_FU functional units. Each FU
//   owns a QDEPTH-entry result FIFO; every cycle one non-empty FIFO is granted
//   and its head is registered onto the wb_* outputs (one-cycle latency,
//   one result per cycle sustained).
//
// Configuration:
//   FU_WB_ARB_PRIORITY_EN  defined   -> non-empty queue 0 (branch unit) always
//                                       wins; rr_ptr is not moved by its grants.
//                          undefined -> pure round-robin starting at rr_ptr+1.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           discard all queued results (rst has priority)
//   req_valid       per-FU result valid
//   req_data        per-FU result data, FU i at slice i
//   req_prn         per-FU destination physical register number
//   req_prn_valid   per-FU "writes a register" flag
//   req_inst_id     per-FU instruction id
//   req_ready       per-FU queue can accept (0 while rst is high)
//   wb_valid        writeback bus carries a result this cycle
//   wb_data, wb_prn, wb_prn_valid, wb_inst_id   granted result fields
//   wb_src          index of the FU whose result is on the bus
// -----------------------------------------------------------------------------
module fu_wb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PRN_W  = 7,
    parameter int unsigned ID_W   = 6,
    parameter int unsigned QDEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_FU-1:0]           req_valid,
    input  logic [NUM_FU*DATA_W-1:0]    req_data,
    input  logic [NUM_FU*PRN_W-1:0]     req_prn,
    input  logic [NUM_FU-1:0]           req_prn_valid,
    input  logic [NUM_FU*ID_W-1:0]      req_inst_id,
    output logic [NUM_FU-1:0]           req_ready,
    output logic                        wb_valid,
    output logic [DATA_W-1:0]           wb_data,
    output logic [PRN_W-1:0]            wb_prn,
    output logic                        wb_prn_valid,
    output logic [ID_W-1:0]             wb_inst_id,
    output logic [$clog2(NUM_FU)-1:0]   wb_src
);

    localparam int unsigned SRC_W = $clog2(NUM_FU);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Per-FU result storage
    logic [DATA_W-1:0] q_data [NUM_FU][QDEPTH];
    logic [PRN_W-1:0]  q_prn  [NUM_FU][QDEPTH];
    logic              q_prnv [NUM_FU][QDEPTH];
    logic [ID_W-1:0]   q_id   [NUM_FU][QDEPTH];

    logic [PTR_W-1:0]  wr_ptr [NUM_FU];
    logic [PTR_W-1:0]  rd_ptr [NUM_FU];
    logic [CNT_W-1:0]  count  [NUM_FU];

    logic [SRC_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] enq;
    logic [NUM_FU-1:0] deq;
    logic              grant_valid;
    logic [SRC_W-1:0]  grant_idx;
    logic              rr_upd;

    // Ready is taken from the count before any same-cycle dequeue, so a full
    // queue never accepts even when it is being granted.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            nonempty[i]  = (count[i] != '0);
            req_ready[i] = !rst && (count[i] < CNT_W'(QDEPTH));
        end
    end

    // Grant selection: scan rr_ptr+1, rr_ptr+2, ... wrapping, first non-empty wins.
    always_comb begin
        logic [SRC_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
`ifdef FU_WB_ARB_PRIORITY_EN
        if (nonempty[0]) begin
            grant_valid = 1'b1;
            grant_idx   = '0;
        end else
`endif
        for (int unsigned k = 1; k <= NUM_FU; k++) begin
            cand = SRC_W'((32'(rr_ptr) + k) % NUM_FU);
            if (!grant_valid && nonempty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
`ifdef FU_WB_ARB_PRIORITY_EN
        // Queue 0 grants are priority grants and leave the rotation alone.
        rr_upd = grant_valid && (grant_idx != '0);
`else
        rr_upd = grant_valid;
`endif
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            enq[i] = req_valid[i] && req_ready[i];
            deq[i] = grant_valid && (grant_idx == SRC_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr       <= SRC_W'(NUM_FU - 1);
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_prn       <= '0;
            wb_prn_valid <= 1'b0;
            wb_inst_id   <= '0;
            wb_src       <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            wb_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (enq[i]) begin
                    q_data[i][wr_ptr[i]] <= req_data[i*DATA_W +: DATA_W];
                    q_prn[i][wr_ptr[i]]  <= req_prn[i*PRN_W +: PRN_W];
                    q_prnv[i][wr_ptr[i]] <= req_prn_valid[i];
                    q_id[i][wr_ptr[i]]   <= req_inst_id[i*ID_W +: ID_W];
                    wr_ptr[i]            <= wr_ptr[i] + PTR_W'(1);
                end
                if (deq[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (enq[i] && !deq[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (deq[i] && !enq[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end

            if (grant_valid) begin
                wb_valid     <= 1'b1;
                wb_data      <= q_data[grant_idx][rd_ptr[grant_idx]];
                wb_prn       <= q_prn[grant_idx][rd_ptr[grant_idx]];
                wb_prn_valid <= q_prnv[grant_idx][rd_ptr[grant_idx]];
                wb_inst_id   <= q_id[grant_idx][rd_ptr[grant_idx]];
                wb_src       <= grant_idx;
                if (rr_upd) begin
                    rr_ptr <= grant_idx;
                end
            end else begin
                // Payload fields hold their previous values when idle.
                wb_valid <= 1'b0;
            end
        end
    end

endmodule
